chimera_bypass_mode_ctrl: RTL and testbench

Sequences run-time changes of the wide-port memory-island bypass mode for one cluster's wide master path. It sits in the SoC clock domain between the wide CDC output and the wide demux. It gates new AW/AR handshakes and tracks outstanding transactions. A mode change is applied only after the wide path has fully drained, so no burst is ever split across the memory island and narrow routes.

---
 rtl/chimera_bypass_mode_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_chimera_bypass_mode_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chimera_bypass_mode_ctrl.sv
// -----------------------------------------------------------------------------
// chimera_bypass_mode_ctrl
//
// Sequences run-time changes of the wide-port memory-island bypass mode for one
// cluster's wide master path. Sits in the SoC clock domain between the wide CDC
// output and the wide demux. New AW/AR handshakes are gated and outstanding
// writes/reads are counted; a mode change is only applied once the wide path
// has fully drained, so no burst is ever split between the memory island route
// and the narrow route.
//
// Ports
//   clk_i, rst_i              SoC clock, synchronous active-high reset
//   aw_valid_i / aw_ready_o   AW handshake towards the upstream (wide CDC)
//   aw_valid_o / aw_ready_i   AW handshake towards the downstream (demux)
//   ar_*                      AR equivalents
//   b_valid_i, b_ready_i      B handshake observed on the upstream side
//   r_valid_i, r_ready_i,
//   r_last_i                  R handshake observed on the upstream side
//   mode_req_valid_i          request to set the bypass mode
//   mode_req_i                requested mode (1 = bypass, wide traffic goes narrow)
//   mode_req_ready_o          request accepted (only while idle)
//   done_o                    one-cycle pulse when a request completes
//   bypass_mode_o             demux select override
//   busy_o                    draining or switching
//   timeout_o                 sticky drain-abort flag, cleared by next accepted request
//   wr_outstanding_o          in-flight write count
//   rd_outstanding_o          in-flight read count
//
// W, B and R are not routed through this block; only AW/AR are gated.
// -----------------------------------------------------------------------------
module chimera_bypass_mode_ctrl #(
  parameter int unsigned MaxOutstanding = 16,
  parameter int unsigned DrainTimeout   = 1024,
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1),
  localparam int unsigned TmoWidth = (DrainTimeout == 0) ? 1 : $clog2(DrainTimeout + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // AW channel
  input  logic                aw_valid_i,
  output logic                aw_ready_o,
  output logic                aw_valid_o,
  input  logic                aw_ready_i,
  // AR channel
  input  logic                ar_valid_i,
  output logic                ar_ready_o,
  output logic                ar_valid_o,
  input  logic                ar_ready_i,
  // Response observation
  input  logic                b_valid_i,
  input  logic                b_ready_i,
  input  logic                r_valid_i,
  input  logic                r_ready_i,
  input  logic                r_last_i,
  // Mode request
  input  logic                mode_req_valid_i,
  input  logic                mode_req_i,
  output logic                mode_req_ready_o,
  output logic                done_o,
  // Status
  output logic                bypass_mode_o,
  output logic                busy_o,
  output logic                timeout_o,
  output logic [CntWidth-1:0] wr_outstanding_o,
  output logic [CntWidth-1:0] rd_outstanding_o
);

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StSwitch
  } state_e;

  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(MaxOutstanding);
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
  localparam logic [TmoWidth-1:0] TmoOne  = TmoWidth'(1);
  localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'((DrainTimeout == 0) ? 0 : DrainTimeout - 1);
  localparam bit                  TmoEn   = (DrainTimeout != 0);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                state_q;
  logic                  target_q;
  logic                  bypass_q;
  logic                  done_q;
  logic                  timeout_q;
  logic [TmoWidth-1:0]   tmo_cnt_q;

  logic [CntWidth-1:0]   wr_q, wr_d;
  logic [CntWidth-1:0]   rd_q, rd_d;
  logic                  aw_pend_q;
  logic                  ar_pend_q;

  // ---------------------------------------------------------------------------
  // Channel gating
  // ---------------------------------------------------------------------------
  logic idle;
  logic blk_aw, blk_ar;
  logic aw_fire, ar_fire;
  logic b_fire, rlast_fire;
  logic b_dec, r_dec;
  logic drained;

  assign idle = (state_q == StIdle);

  // A valid already presented downstream must be kept until it handshakes, so a
  // pending address overrides both the mode-change block and the count limit.
  assign blk_aw = (~idle | (wr_q == CntMax)) & ~aw_pend_q;
  assign blk_ar = (~idle | (rd_q == CntMax)) & ~ar_pend_q;

  assign aw_valid_o = aw_valid_i & ~blk_aw;
  assign aw_ready_o = aw_ready_i & ~blk_aw;
  assign ar_valid_o = ar_valid_i & ~blk_ar;
  assign ar_ready_o = ar_ready_i & ~blk_ar;

  assign aw_fire    = aw_valid_o & aw_ready_i;
  assign ar_fire    = ar_valid_o & ar_ready_i;
  assign b_fire     = b_valid_i & b_ready_i;
  assign rlast_fire = r_valid_i & r_ready_i & r_last_i;

  // Responses with nothing outstanding are dropped rather than wrapping the count.
  assign b_dec = b_fire & (wr_q != '0);
  assign r_dec = rlast_fire & (rd_q != '0);

  assign drained = (wr_q == '0) & (rd_q == '0) & ~aw_pend_q & ~ar_pend_q;

  // ---------------------------------------------------------------------------
  // Outstanding counters
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_d = wr_q;
    case ({aw_fire, b_dec})
      2'b10: begin
        if (wr_q != CntMax) wr_d = wr_q + CntOne;
      end
      2'b01:   wr_d = wr_q - CntOne;
      default: wr_d = wr_q;
    endcase
  end

  always_comb begin
    rd_d = rd_q;
    case ({ar_fire, r_dec})
      2'b10: begin
        if (rd_q != CntMax) rd_d = rd_q + CntOne;
      end
      2'b01:   rd_d = rd_q - CntOne;
      default: rd_d = rd_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q      <= '0;
      rd_q      <= '0;
      aw_pend_q <= 1'b0;
      ar_pend_q <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      aw_pend_q <= aw_valid_o & ~aw_ready_i;
      ar_pend_q <= ar_valid_o & ~ar_ready_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Mode-change FSM
  // ---------------------------------------------------------------------------
  // The new mode and done pulse are registered on entry to StSwitch, so during
  // the switch cycle the demux already sees the new select while AW/AR are
  // still blocked.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      target_q  <= 1'b0;
      bypass_q  <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (mode_req_valid_i) begin
            timeout_q <= 1'b0;
            if (mode_req_i == bypass_q) begin
              done_q <= 1'b1;
            end else begin
              target_q  <= mode_req_i;
              tmo_cnt_q <= '0;
              state_q   <= StDrain;
            end
          end
        end
        StDrain: begin
          tmo_cnt_q <= tmo_cnt_q + TmoOne;
          // Completing the drain wins over a timeout hitting in the same cycle.
          if (drained) begin
            bypass_q <= target_q;
            done_q   <= 1'b1;
            state_q  <= StSwitch;
          end else if (TmoEn && (tmo_cnt_q == TmoLast)) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= StIdle;
          end
        end
        StSwitch: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mode_req_ready_o = idle;
  assign busy_o           = ~idle;
  assign done_o           = done_q;
  assign bypass_mode_o    = bypass_q;
  assign timeout_o        = timeout_q;
  assign wr_outstanding_o = wr_q;
  assign rd_outstanding_o = rd_q;

  // A response with nothing outstanding means the upstream protocol is broken.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(b_fire && (wr_q == '0)));
      assert (!(rlast_fire && (rd_q == '0)));
    end
  end

endmodule

// File: tb/tb_chimera_bypass_mode_ctrl.sv
module tb_chimera_bypass_mode_ctrl;

  localparam int MaxOut = 16;
  localparam int Tmo    = 8;
  localparam int CW     = $clog2(MaxOut + 1);

  logic clk = 1'b0;
  logic rst_i;
  logic aw_valid_i, aw_ready_o, aw_valid_o, aw_ready_i;
  logic ar_valid_i, ar_ready_o, ar_valid_o, ar_ready_i;
  logic b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i;
  logic mode_req_valid_i, mode_req_i, mode_req_ready_o, done_o;
  logic bypass_mode_o, busy_o, timeout_o;
  logic [CW-1:0] wr_outstanding_o, rd_outstanding_o;

  chimera_bypass_mode_ctrl #(
    .MaxOutstanding(MaxOut),
    .DrainTimeout  (Tmo)
  ) u_dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .aw_valid_i      (aw_valid_i),
    .aw_ready_o      (aw_ready_o),
    .aw_valid_o      (aw_valid_o),
    .aw_ready_i      (aw_ready_i),
    .ar_valid_i      (ar_valid_i),
    .ar_ready_o      (ar_ready_o),
    .ar_valid_o      (ar_valid_o),
    .ar_ready_i      (ar_ready_i),
    .b_valid_i       (b_valid_i),
    .b_ready_i       (b_ready_i),
    .r_valid_i       (r_valid_i),
    .r_ready_i       (r_ready_i),
    .r_last_i        (r_last_i),
    .mode_req_valid_i(mode_req_valid_i),
    .mode_req_i      (mode_req_i),
    .mode_req_ready_o(mode_req_ready_o),
    .done_o          (done_o),
    .bypass_mode_o   (bypass_mode_o),
    .busy_o          (busy_o),
    .timeout_o       (timeout_o),
    .wr_outstanding_o(wr_outstanding_o),
    .rd_outstanding_o(rd_outstanding_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: request phase, drain age, mode and plain integer counts.
  int m_drain_age;  // -1 when not draining, else cycles spent draining
  bit m_switching, m_mode, m_target, m_done, m_tmo, m_awp, m_arp;
  int m_wr, m_rd;
  bit e_aw_v, e_aw_r, e_ar_v, e_ar_r;

  logic [2*CW+8:0] obs_vec, exp_vec;
  assign obs_vec = {aw_valid_o, aw_ready_o, ar_valid_o, ar_ready_o, mode_req_ready_o, done_o,
                    bypass_mode_o, busy_o, timeout_o, wr_outstanding_o, rd_outstanding_o};

  task automatic model_reset();
    m_drain_age = -1;
    m_switching = 0; m_mode = 0; m_target = 0; m_done = 0; m_tmo = 0;
    m_awp = 0; m_arp = 0; m_wr = 0; m_rd = 0;
  endtask

  task automatic idle_inputs();
    aw_valid_i = 0; aw_ready_i = 0; ar_valid_i = 0; ar_ready_i = 0;
    b_valid_i = 0; b_ready_i = 0; r_valid_i = 0; r_ready_i = 0; r_last_i = 0;
    mode_req_valid_i = 0; mode_req_i = 0;
  endtask

  // Expected outputs for the current cycle, evaluated mid-cycle.
  task automatic predict();
    bit busy, blk_aw, blk_ar;
    @(negedge clk);
    busy   = (m_drain_age >= 0) || m_switching;
    blk_aw = (busy || m_wr == MaxOut) && !m_awp;
    blk_ar = (busy || m_rd == MaxOut) && !m_arp;
    e_aw_v = aw_valid_i && !blk_aw;
    e_aw_r = aw_ready_i && !blk_aw;
    e_ar_v = ar_valid_i && !blk_ar;
    e_ar_r = ar_ready_i && !blk_ar;
    exp_vec = {e_aw_v, e_aw_r, e_ar_v, e_ar_r, !busy, m_done, m_mode, busy, m_tmo,
               CW'(m_wr), CW'(m_rd)};
  endtask

  // Clock edge: advance the model with the inputs of the cycle just ended.
  task automatic advance();
    bit aw_f, ar_f, b_f, rl_f, drained;
    @(posedge clk);
    if (rst_i) begin
      model_reset();
    end else begin
      aw_f = e_aw_v && aw_ready_i;
      ar_f = e_ar_v && ar_ready_i;
      b_f  = b_valid_i && b_ready_i && (m_wr > 0);
      rl_f = r_valid_i && r_ready_i && r_last_i && (m_rd > 0);
      drained = (m_wr == 0) && (m_rd == 0) && !m_awp && !m_arp;
      m_done = 0;
      if (m_switching) begin
        m_switching = 0;
      end else if (m_drain_age >= 0) begin
        if (drained) begin
          m_drain_age = -1; m_switching = 1; m_mode = m_target; m_done = 1;
        end else if (m_drain_age == Tmo - 1) begin
          m_drain_age = -1; m_tmo = 1; m_done = 1;
        end else begin
          m_drain_age++;
        end
      end else if (mode_req_valid_i) begin
        m_tmo = 0;
        if (mode_req_i == m_mode) m_done = 1;
        else begin
          m_target = mode_req_i; m_drain_age = 0;
        end
      end
      m_wr = m_wr + int'(aw_f) - int'(b_f);
      m_rd = m_rd + int'(ar_f) - int'(rl_f);
      if (m_wr > MaxOut) m_wr = MaxOut;
      if (m_rd > MaxOut) m_rd = MaxOut;
      m_awp = e_aw_v && !aw_ready_i;
      m_arp = e_ar_v && !ar_ready_i;
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1;
    repeat (2) begin
      predict();
      advance();
    end
    rst_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    predict();
    n_checks++;
    if ({mode_req_ready_o, done_o, bypass_mode_o, busy_o, timeout_o, wr_outstanding_o,
         rd_outstanding_o} !== {1'b1, 4'b0, {(2*CW){1'b0}}}) begin
      n_errors++;
      $display("FAIL reset_state got=%h required ready=1 others=0", obs_vec);
    end
    n_checks++;
    if (obs_vec !== exp_vec) begin
      n_errors++;
      $display("FAIL reset_model got=%h exp=%h", obs_vec, exp_vec);
    end
    advance();
  endtask

  task automatic test_idle_switch();
    logic [3:0] busy_tab = 4'b0110, done_tab = 4'b0100, byp_tab = 4'b1100;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      idle_inputs();
      if (k == 0) begin mode_req_valid_i = 1; mode_req_i = 1; end
      predict();
      n_checks++;
      if ({busy_o, done_o, bypass_mode_o} !== {busy_tab[k], done_tab[k], byp_tab[k]}) begin
        n_errors++;
        $display("FAIL idle_switch_seq k=%0d got busy/done/byp=%b%b%b exp=%b%b%b", k, busy_o,
                 done_o, bypass_mode_o, busy_tab[k], done_tab[k], byp_tab[k]);
      end
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL idle_switch_model k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_noop();
    logic [2:0] done_tab = 3'b010;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      aw_ready_i = 1; ar_ready_i = 1;
      if (k == 0) begin mode_req_valid_i = 1; mode_req_i = 0; end
      predict();
      n_checks++;
      if ({done_o, busy_o, aw_ready_o, ar_ready_o} !== {done_tab[k], 1'b0, 1'b1, 1'b1}) begin
        n_errors++;
        $display("FAIL noop k=%0d got done/busy/awr/arr=%b%b%b%b exp=%b011", k, done_o, busy_o,
                 aw_ready_o, ar_ready_o, done_tab[k]);
      end
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL noop_model k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_drain();
    int last_cmp = 12;
    int flip_k = -1;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      idle_inputs();
      if (k <= 2) begin aw_valid_i = 1; aw_ready_i = 1; end
      if (k <= 1) begin ar_valid_i = 1; ar_ready_i = 1; end
      if (k >= 3 && k <= 6) begin r_valid_i = 1; r_ready_i = 1; r_last_i = (k == 6); end
      if (k == 7) begin mode_req_valid_i = 1; mode_req_i = 1; end
      if (k >= 8) begin
        aw_valid_i = 1; aw_ready_i = 1; ar_valid_i = 1; ar_ready_i = 1;
      end
      if (k >= 8 && k <= 11) begin r_valid_i = 1; r_ready_i = 1; r_last_i = (k == 11); end
      if (k >= 10 && k <= 12) begin b_valid_i = 1; b_ready_i = 1; end
      predict();
      if (flip_k < 0 && bypass_mode_o === 1'b1) flip_k = k;
      if (k >= 8 && k <= 14) begin
        n_checks++;
        if ({aw_valid_o, ar_valid_o} !== 2'b00) begin
          n_errors++;
          $display("FAIL drain_block k=%0d got aw/ar valid=%b%b exp=00", k, aw_valid_o,
                   ar_valid_o);
        end
      end
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL drain_model k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      advance();
    end
    n_checks++;
    if (flip_k != last_cmp + 2) begin
      n_errors++;
      $display("FAIL drain_flip_cycle got=%0d exp=%0d", flip_k, last_cmp + 2);
    end
  endtask

  task automatic test_pending_aw();
    do_reset();
    for (int k = 0; k < 9; k++) begin
      idle_inputs();
      if (k <= 4) begin aw_valid_i = 1; aw_ready_i = (k == 4); end
      if (k == 0) begin mode_req_valid_i = 1; mode_req_i = 1; end
      if (k == 5) begin b_valid_i = 1; b_ready_i = 1; end
      predict();
      if (k <= 4) begin
        n_checks++;
        if (aw_valid_o !== 1'b1) begin
          n_errors++;
          $display("FAIL pend_aw_hold k=%0d got=%b exp=1", k, aw_valid_o);
        end
      end
      if (k == 5 || k == 7) begin
        n_checks++;
        if ({wr_outstanding_o, busy_o, bypass_mode_o} !== {CW'(k == 5), 1'b1, (k == 7)}) begin
          n_errors++;
          $display("FAIL pend_aw_drain k=%0d got wr=%0d busy=%b byp=%b", k, wr_outstanding_o,
                   busy_o, bypass_mode_o);
        end
      end
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL pend_aw_model k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_limit();
    do_reset();
    for (int k = 0; k < 21; k++) begin
      idle_inputs();
      if (k <= 19) begin aw_valid_i = 1; aw_ready_i = 1; end
      if (k == 16 || k == 18 || k == 19) begin b_valid_i = 1; b_ready_i = 1; end
      predict();
      if (k == 16 || k == 18) begin
        n_checks++;
        if ({aw_ready_o, aw_valid_o, wr_outstanding_o} !== {2'b00, CW'(MaxOut)}) begin
          n_errors++;
          $display("FAIL limit_block k=%0d got rdy=%b vld=%b wr=%0d exp 0 0 %0d", k,
                   aw_ready_o, aw_valid_o, wr_outstanding_o, MaxOut);
        end
      end
      if (k == 17 || k == 19) begin
        n_checks++;
        if (aw_ready_o !== 1'b1) begin
          n_errors++;
          $display("FAIL limit_accept k=%0d got=%b exp=1", k, aw_ready_o);
        end
      end
      if (k == 20) begin
        n_checks++;
        if (wr_outstanding_o !== CW'(MaxOut - 1)) begin
          n_errors++;
          $display("FAIL limit_simul got=%0d exp=%0d", wr_outstanding_o, MaxOut - 1);
        end
      end
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL limit_model k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 0; k < 13; k++) begin
      idle_inputs();
      if (k == 0 || (k >= 2 && k <= 10)) begin ar_valid_i = 1; ar_ready_i = 1; end
      if (k == 1 || k == 11) begin mode_req_valid_i = 1; mode_req_i = 1; end
      predict();
      if (k >= 2 && k <= 9) begin
        n_checks++;
        if ({busy_o, ar_valid_o, timeout_o} !== 3'b100) begin
          n_errors++;
          $display("FAIL tmo_drain k=%0d got busy/arv/tmo=%b%b%b exp=100", k, busy_o,
                   ar_valid_o, timeout_o);
        end
      end
      if (k == 10) begin
        n_checks++;
        if ({timeout_o, done_o, bypass_mode_o, busy_o, ar_valid_o} !== 5'b11001) begin
          n_errors++;
          $display("FAIL tmo_abort got tmo/done/byp/busy/arv=%b%b%b%b%b exp=11001", timeout_o,
                   done_o, bypass_mode_o, busy_o, ar_valid_o);
        end
      end
      if (k == 12) begin
        n_checks++;
        if ({timeout_o, busy_o} !== 2'b01) begin
          n_errors++;
          $display("FAIL tmo_clear got tmo/busy=%b%b exp=01", timeout_o, busy_o);
        end
      end
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL tmo_model k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_random();
    bit aw_hold = 0, ar_hold = 0;
    int b_rate;
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      b_rate = ((k / 500) % 2 == 0) ? 1 : 6;
      rst_i            = ($urandom_range(0, 599) == 0);
      aw_valid_i       = aw_hold || ($urandom_range(0, 2) == 0);
      ar_valid_i       = ar_hold || ($urandom_range(0, 2) == 0);
      aw_ready_i       = ($urandom_range(0, 3) != 0);
      ar_ready_i       = ($urandom_range(0, 3) != 0);
      b_valid_i        = (m_wr > 0) && ($urandom_range(0, 7) < b_rate);
      b_ready_i        = ($urandom_range(0, 3) != 0);
      r_valid_i        = (m_rd > 0) && ($urandom_range(0, 1) == 0);
      r_ready_i        = ($urandom_range(0, 3) != 0);
      r_last_i         = ($urandom_range(0, 2) == 0);
      mode_req_valid_i = ($urandom_range(0, 15) == 0);
      mode_req_i       = 1'($urandom_range(0, 1));
      predict();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL random_model k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      aw_hold = !rst_i && aw_valid_i && !e_aw_r;
      ar_hold = !rst_i && ar_valid_i && !e_ar_r;
      advance();
    end
    rst_i = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    model_reset();
    idle_inputs();
    rst_i = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_idle_switch();
    test_noop();
    test_drain();
    test_pending_aw();
    test_limit();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
